// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type, grant index type and round-robin helper for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam int MAX_REQ = 32;
  localparam int IDX_W   = $clog2(MAX_REQ);

  typedef logic [IDX_W-1:0] grant_idx_t;

  // First set bit strictly after ptr, wrapping over n requesters; -1 when none is set.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
    grant_idx_t idx;
    rr_pick = -1;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = grant_idx_t'((ptr + k) % n);
        if (valid[idx]) rr_pick = int'(idx);
      end
    end
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker: valid vector + last winner -> next winner
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [GW-1:0]      i_ptr,
  output logic [GW-1:0]      o_grant,
  output logic               o_any_valid
);

  logic [MAX_REQ-1:0] w_valid_ext;

  always_comb begin
    w_valid_ext                = '0;
    w_valid_ext[NUM_REQ-1:0]   = i_valid;
    o_grant                    = GW'(rr_pick(w_valid_ext, int'(i_ptr), NUM_REQ));
  end

  assign o_any_valid = |i_valid;

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// rtl/fifo_rr_write_arbiter.sv - round-robin burst arbiter sharing one FIFO producer port among NUM_REQ requesters
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int MAX_BURST  = 8,
  parameter int STAT_WIDTH = 32,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_alm_full,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic [STAT_WIDTH-1:0]         stall_cycles
);

  localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);

  state_t                r_state;
  logic [GW-1:0]         r_grant;
  logic [GW-1:0]         r_rr_ptr;
  logic [BC_W-1:0]       r_beat_cnt;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic [STAT_WIDTH-1:0] r_stall;

  logic [GW-1:0]         w_pick;
  logic                  w_any_valid;
  logic                  w_space;
  logic                  w_in_burst;
  logic                  w_gnt_valid;
  logic                  w_gnt_last;
  logic                  w_accept;
  logic                  w_burst_end;
  logic [DATA_WIDTH-1:0] w_beats [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_beats[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_valid     (req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_pick),
    .o_any_valid (w_any_valid)
  );

  // alm_full leaves room for the one beat already sitting in the write register.
  assign w_space     = !fifo_alm_full && !fifo_full;
  assign w_in_burst  = (r_state == BURST);
  assign w_gnt_valid = req_valid[r_grant];
  assign w_gnt_last  = req_last[r_grant];
  assign w_accept    = w_in_burst && w_gnt_valid && w_space;
  assign w_burst_end = w_accept && (w_gnt_last || (r_beat_cnt == LAST_BEAT));

  always_comb begin
    req_ready = '0;
    if (w_in_burst) req_ready[r_grant] = w_space;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= GW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_state    <= BURST;
            r_grant    <= w_pick;
            r_beat_cnt <= '0;
          end
        end
        BURST: begin
          if (w_burst_end) begin
            r_state  <= IDLE;
            r_rr_ptr <= r_grant;
          end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + BC_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en <= 1'b0;
      r_data  <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) r_data <= w_beats[r_grant];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if (w_in_burst && w_gnt_valid && !w_space && (r_stall != '1)) begin
      r_stall <= r_stall + STAT_WIDTH'(1);
    end
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_data_in = r_data;
  assign grant_id     = r_grant;
  assign busy         = w_in_burst;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// tb/tb_fifo_rr_write_arbiter.sv - directed bench with behavioural arbiter model for fifo_rr_write_arbiter
module tb_fifo_rr_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int SW = 4;
  localparam int SAT = (1 << SW) - 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic            fifo_full;
  logic            fifo_alm_full;
  logic [1:0]      grant_id;
  logic            busy;
  logic [SW-1:0]   stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_rr_write_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .STAT_WIDTH(SW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_full     (fifo_full),
    .fifo_alm_full (fifo_alm_full),
    .grant_id      (grant_id),
    .busy          (busy),
    .stall_cycles  (stall_cycles)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            gap;
  } beat_t;

  beat_t         q [NR][$];
  logic [NR-1:0] acc;
  logic [DW-1:0] wlog [$];
  int            wcyc [$];
  int            cyc = 0;

  bit            m_busy;
  int            m_grant, m_ptr, m_cnt, m_stall;
  bit            m_wr;
  logic [DW-1:0] m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: one burst per grant, one idle cycle between grants, round-robin after the last winner.
  always @(negedge clk) begin : cmp
    logic [NR-1:0] exp_ready;
    bit            room;
    bit            acc_m;
    int            nxt;
    int            idx;
    cyc++;
    if (!reset_n) begin
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
      check("rst_data", 64'(fifo_data_in), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_grant", 64'(grant_id), 64'd0);
      check("rst_stall", 64'(stall_cycles), 64'd0);
      m_busy = 0; m_grant = 0; m_ptr = NR - 1; m_cnt = 0;
      m_stall = 0; m_wr = 0; m_data = '0; acc = '0;
    end else begin
      room = !fifo_alm_full && !fifo_full;
      exp_ready = '0;
      if (m_busy && room) exp_ready[m_grant] = 1'b1;
      check("ready", 64'(req_ready), 64'(exp_ready));
      check("busy", 64'(busy), 64'(m_busy));
      check("grant_id", 64'(grant_id), 64'(m_grant));
      check("wr_en", 64'(fifo_wr_en), 64'(m_wr));
      check("data_in", 64'(fifo_data_in), 64'(m_data));
      check("stall", 64'(stall_cycles), 64'(m_stall));
      check("wr_while_full", 64'(fifo_wr_en && fifo_full), 64'd0);
      if (fifo_wr_en) begin
        wlog.push_back(fifo_data_in);
        wcyc.push_back(cyc);
      end
      acc = req_valid & req_ready;

      acc_m = m_busy && req_valid[m_grant] && room;
      m_wr  = acc_m;
      if (acc_m) m_data = req_data[m_grant*DW +: DW];
      if (m_busy && req_valid[m_grant] && !room && m_stall < SAT) m_stall++;
      if (!m_busy) begin
        nxt = -1;
        for (int k = 1; k <= NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (nxt < 0 && req_valid[idx]) nxt = idx;
        end
        if (nxt >= 0) begin
          m_busy = 1; m_grant = nxt; m_cnt = 0;
        end
      end else if (acc_m) begin
        if (req_last[m_grant] || m_cnt == MB - 1) begin
          m_busy = 0; m_ptr = m_grant;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  always @(posedge clk) begin : drv
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i] && q[i].size() > 0) q[i].delete(0);
      req_valid[i] = 1'b0;
      req_last[i]  = 1'b0;
      if (q[i].size() > 0) begin
        if (q[i][0].gap > 0) begin
          q[i][0].gap = q[i][0].gap - 1;
        end else begin
          req_valid[i]          = 1'b1;
          req_last[i]           = q[i][0].last;
          req_data[i*DW +: DW]  = q[i][0].data;
        end
      end
    end
    acc = '0;
  end

  task automatic push(input int i, input logic [DW-1:0] d, input logic l, input int gap);
    beat_t b;
    b.data = d; b.last = l; b.gap = gap;
    q[i].push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset_n = 1'b0; fifo_alm_full = 1'b0; fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) q[i].delete();
    repeat (2) @(negedge clk);
    wlog.delete(); wcyc.delete();
    @(posedge clk); #2 reset_n = 1'b1;
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    int c = 0;
    while (wlog.size() < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check(name, 64'(wlog.size() >= n), 64'd1);
  endtask

  task automatic expect_log(input string name, input logic [DW-1:0] e [$]);
    check({name, "_count"}, 64'(wlog.size()), 64'(e.size()));
    for (int k = 0; k < e.size() && k < wlog.size(); k++)
      check($sformatf("%s_%0d", name, k), 64'(wlog[k]), 64'(e[k]));
  endtask

  initial begin : main
    logic [DW-1:0] e [$];
    int c;
    reset_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    fifo_full = 1'b0; fifo_alm_full = 1'b0; acc = '0;
    do_reset();
    @(negedge clk); #1;
    check("init_busy", 64'(busy), 64'd0);
    check("init_stall", 64'(stall_cycles), 64'd0);

    // 1: reset in the middle of a burst while a write is leaving
    push(0, 32'h0000_0000, 0, 0); push(0, 32'h0000_0001, 0, 0);
    push(0, 32'h0000_0002, 0, 0); push(0, 32'h0000_0003, 1, 0);
    c = 0;
    while (!fifo_wr_en && c < 20) begin @(negedge clk); c++; end
    check("t1_wr_seen", 64'(fifo_wr_en), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("t1_async_wr", 64'(fifo_wr_en), 64'd0);
    check("t1_async_busy", 64'(busy), 64'd0);
    check("t1_async_ready", 64'(req_ready), 64'd0);
    check("t1_async_data", 64'(fifo_data_in), 64'd0);
    for (int i = 0; i < NR; i++) q[i].delete();
    repeat (2) @(negedge clk);
    wlog.delete(); wcyc.delete();
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    push(1, 32'h0001_0010, 1, 0); push(0, 32'h0000_0010, 1, 0);
    wait_writes("t1_done", 2, 20);
    e = {32'h0000_0010, 32'h0001_0010};
    expect_log("t1_order", e);

    // 2: four contenders, single-beat bursts
    do_reset();
    @(negedge clk);
    push(0, 32'h0000_0000, 1, 0); push(0, 32'h0000_0001, 1, 0);
    push(1, 32'h0001_0000, 1, 0); push(2, 32'h0002_0000, 1, 0);
    push(3, 32'h0003_0000, 1, 0);
    wait_writes("t2_done", 5, 40);
    e = {32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0000_0001};
    expect_log("t2_order", e);
    for (int k = 0; k + 1 < wcyc.size(); k++)
      check($sformatf("t2_spacing_%0d", k), 64'(wcyc[k+1] - wcyc[k]), 64'd2);

    // 3: 20-beat burst cut at 8 beats, interleaved with another requester
    do_reset();
    @(negedge clk);
    for (int b = 0; b < 20; b++) push(1, 32'h0001_0000 + DW'(b), (b == 19), 0);
    push(2, 32'h0002_0000, 0, 0); push(2, 32'h0002_0001, 1, 0);
    wait_writes("t3_done", 22, 200);
    e = {};
    for (int b = 0; b < 8; b++) e.push_back(32'h0001_0000 + DW'(b));
    e.push_back(32'h0002_0000); e.push_back(32'h0002_0001);
    for (int b = 8; b < 20; b++) e.push_back(32'h0001_0000 + DW'(b));
    expect_log("t3_order", e);

    // 4: alm_full (and briefly full) for 4 cycles starting at beat 3 of 5
    do_reset();
    @(negedge clk);
    for (int b = 0; b < 5; b++) push(0, 32'h0000_0040 + DW'(b), (b == 4), 0);
    wait_writes("t4_first", 1, 20);
    @(posedge clk); #1 fifo_alm_full = 1'b1;
    @(posedge clk); #1 fifo_full = 1'b1;
    @(negedge clk);
    check("t4_ready_held", 64'(req_ready), 64'd0);
    check("t4_busy_held", 64'(busy), 64'd1);
    check("t4_grant_held", 64'(grant_id), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 fifo_full = 1'b0;
    @(posedge clk); #1 fifo_alm_full = 1'b0;
    wait_writes("t4_done", 5, 40);
    check("t4_stall", 64'(stall_cycles), 64'd4);
    e = {32'h0000_0040, 32'h0000_0041, 32'h0000_0042, 32'h0000_0043, 32'h0000_0044};
    expect_log("t4_order", e);

    // 5: granted requester goes quiet mid-burst while another waits
    do_reset();
    @(negedge clk);
    for (int b = 0; b < 4; b++) push(2, 32'h0002_0050 + DW'(b), (b == 3), (b == 2) ? 3 : 0);
    c = 0;
    while (!busy && c < 20) begin @(negedge clk); c++; end
    check("t5_granted", 64'(busy), 64'd1);
    push(0, 32'h0000_0050, 0, 0); push(0, 32'h0000_0051, 1, 0);
    c = 0;
    while (!(busy && !req_valid[2]) && c < 20) begin @(negedge clk); #1; c++; end
    check("t5_gap_busy", 64'(busy), 64'd1);
    check("t5_gap_grant", 64'(grant_id), 64'd2);
    check("t5_gap_ready0", 64'(req_ready[0]), 64'd0);
    wait_writes("t5_done", 6, 60);
    e = {32'h0002_0050, 32'h0002_0051, 32'h0002_0052, 32'h0002_0053, 32'h0000_0050, 32'h0000_0051};
    expect_log("t5_order", e);

    // 6: stall counter saturation
    do_reset();
    @(negedge clk);
    fifo_alm_full = 1'b1;
    push(3, 32'h0003_0060, 1, 0);
    repeat (25) @(negedge clk);
    #1 check("t6_sat", 64'(stall_cycles), 64'd15);
    repeat (5) @(negedge clk);
    #1 check("t6_sat_hold", 64'(stall_cycles), 64'd15);
    @(posedge clk); #1 fifo_alm_full = 1'b0;
    wait_writes("t6_done", 1, 20);
    e = {32'h0003_0060};
    expect_log("t6_order", e);
    check("t6_sat_after", 64'(stall_cycles), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
